pe_dot_sched: RTL and testbench
===============================

Name: pe_dot_sched

Overview:
- Sequencer for one multiply-accumulate PE: 3-stage pipeline (input reg, multiply, accumulate); start clears the accumulator; output_valid pulses with last.
- Accepts a dot-product command (two operand base addresses, strides, length K).
- Streams operand reads from two 1-cycle-latency operand RAMs into the PE, drives start/valid_in/last, and waits for the PE result.
- Returns the result over a valid/ready handshake; flags a timeout if the PE never answers.

Parameters:
- DATA_WIDTH, 32, operand width.
- ACC_WIDTH, 2*DATA_WIDTH, result width; must match the PE.
- ADDR_WIDTH, 10, operand RAM address width.
- LEN_WIDTH, 10, width of the K field.
- TIMEOUT, 16, cycles allowed from last issue to PE output_valid.

Ports:
- clk  in  1  clock.
- clr  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  scheduler idle, accepts command.
- cmd_a_base  in  ADDR_WIDTH  first A address.
- cmd_b_base  in  ADDR_WIDTH  first B address.
- cmd_a_stride  in  ADDR_WIDTH  A address increment.
- cmd_b_stride  in  ADDR_WIDTH  B address increment.
- cmd_len  in  LEN_WIDTH  K, number of products.
- a_rd_en, b_rd_en  out  1  RAM read enables.
- a_rd_addr, b_rd_addr  out  ADDR_WIDTH  RAM addresses.
- a_rd_data, b_rd_data  in  DATA_WIDTH  RAM data, valid 1 cycle after rd_en.
- pe_start  out  1  to PE start.
- pe_valid_in  out  1  to PE valid_in.
- pe_last  out  1  to PE last.
- pe_a, pe_b  out  DATA_WIDTH  to PE a/b; combinational pass of rd_data.
- pe_c  in  ACC_WIDTH  PE result.
- pe_output_valid  in  1  PE result valid.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  ACC_WIDTH  captured sum.
- res_timeout  out  1  qualifies res_data as invalid (0) due to timeout.

Behaviour:
- Reset (clr high at a clk edge): state IDLE. cmd_ready=1 in the cycle after reset; all other outputs and counters 0. Reset mid-operation abandons the command with no result. PE pipeline leftovers are flushed by the next CLEAR.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch the command fields and go to CLEAR. If cmd_len==0, go directly to DONE with res_data=0, res_timeout=0, and make no RAM or PE activity.
- CLEAR: exactly 3 cycles with pe_start=1 and no reads. This guarantees every in-flight PE stage is flushed and the accumulator is zero. Then go to ISSUE.
- ISSUE: K cycles.
  - a_rd_en=b_rd_en=1.
  - Address i (i=0..K-1) is base+i*stride, computed by incremental add, wrapping modulo 2^ADDR_WIDTH.
  - After the K-th read, go to WAIT.
- PE drive:
  - pe_valid_in is rd_en delayed 1 register.
  - pe_last is the registered flag "this read is i==K-1", 1 cycle delayed.
  - pe_a/pe_b = rd_data.
- WAIT:
  - Timeout counter starts at 0 on entry and increments each cycle.
  - On pe_output_valid: res_data<=pe_c, res_timeout<=0, go to DONE.
  - If the counter reaches TIMEOUT first: res_data<=0, res_timeout<=1, go to DONE.
  - pe_output_valid outside WAIT is ignored.
- DONE:
  - res_valid=1, res_data and res_timeout held stable until res_ready.
  - On res_valid&res_ready, go to IDLE; cmd_ready=1 next cycle.
  - Commands are not accepted while busy.
- Latency: command accepted at edge 0.
  - CLEAR covers cycles 1-3.
  - Reads cover cycles 4..K+3; pe_valid_in covers cycles 5..K+4.
  - pe_output_valid arrives in cycle K+7; res_valid rises in cycle K+8.
  - cmd-to-res latency is K+8 cycles.
- Throughput: one product per cycle; no bubbles in ISSUE.
- Length counter is LEN_WIDTH bits; maximum K = 2^LEN_WIDTH-1.

Optional Feature:
- Macro PE_DOT_SCHED_PERF_EN.
- When defined, add outputs:
  - perf_busy_cycles [31:0]: increments every cycle state!=IDLE.
  - perf_cmds [15:0]: increments per accepted command.
  - perf_timeouts [15:0]: increments per timeout.
- All three counters saturate, and are cleared by clr.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pe_sched_pkg holds:
  - state encoding IDLE/CLEAR/ISSUE/WAIT/DONE;
  - CLEAR_CYCLES=3;
  - RAM_RD_LAT=1;
  - PE_LAT=3.
- One natural sub-module: pe_sched_addr_gen. It is the per-operand base/stride incrementing address counter, instantiated twice (A, B).

Test Plan:
- K=4, A={1,2,3,4}, B={5,6,7,8}, strides 1, bases 0/0 with the real PE -> res_data=70, res_timeout=0, res_valid in cycle 12 after accept.
- Back-to-back commands K=3 then K=2, res_ready tied high. Second result must exclude first-run products: A=B={2,2,2} -> 12; then A=B={3,3} -> 18.
- cmd_len=0 -> res_valid within 2 cycles, res_data=0, no rd_en or pe_start pulses.
- Stub PE that never asserts output_valid, TIMEOUT=16 -> res_timeout=1, res_data=0 exactly 16 cycles after WAIT entry.
- Stride/wrap: ADDR_WIDTH=4, a_base=14, stride=3, K=3 -> a_rd_addr sequence 14,1,4.
- clr asserted mid-ISSUE, then new command K=2 with A=B={1,1} -> result 2. No stale accumulation; cmd_ready=1 the cycle after reset.

Source files
------------

// File: rtl/pe_sched_pkg.sv
// Shared types and timing constants for the pe_dot_sched dot-product sequencer.
package pe_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } sched_state_e;

  localparam int CLEAR_CYCLES = 3;
  localparam int RAM_RD_LAT   = 1;
  localparam int PE_LAT       = 3;

  // Accept edge to res_valid: CLEAR, K reads, RAM latency, PE pipeline, WAIT->DONE.
  function automatic int cmd_to_res_latency(input int len);
    return CLEAR_CYCLES + len + RAM_RD_LAT + PE_LAT + 1;
  endfunction

endpackage

// File: rtl/pe_dot_sched_if.sv
// Command and result handshake channels between a requester and pe_dot_sched.
interface pe_dot_sched_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10,
  parameter int ACC_WIDTH  = 64
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_a_base;
  logic [ADDR_WIDTH-1:0] cmd_b_base;
  logic [ADDR_WIDTH-1:0] cmd_a_stride;
  logic [ADDR_WIDTH-1:0] cmd_b_stride;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  res_data;
  logic                  res_timeout;

  modport master (
    output cmd_valid, cmd_a_base, cmd_b_base, cmd_a_stride, cmd_b_stride, cmd_len,
    input  cmd_ready,
    input  res_valid, res_data, res_timeout,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_a_base, cmd_b_base, cmd_a_stride, cmd_b_stride, cmd_len,
    output cmd_ready,
    output res_valid, res_data, res_timeout,
    input  res_ready
  );

endinterface

// File: rtl/pe_sched_addr_gen.sv
// Per-operand address counter: loads base/stride, then adds stride once per read.
module pe_sched_addr_gen #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] stride_q;

  always_ff @(posedge clk) begin
    // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
    if (clr) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
    end else if (step) begin
      addr     <= addr + stride_q;  // wraps modulo 2^ADDR_WIDTH
    end
  end

endmodule

// File: rtl/pe_dot_sched.sv
// Dot-product sequencer for one 3-stage MAC PE: clears the PE, streams K operand
// pairs, waits for the sum. Optional perf counters: define PE_DOT_SCHED_PERF_EN.
module pe_dot_sched
  import pe_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  pe_dot_sched_if.slave         bus,
  output logic                  a_rd_en,
  output logic                  b_rd_en,
  output logic [ADDR_WIDTH-1:0] a_rd_addr,
  output logic [ADDR_WIDTH-1:0] b_rd_addr,
  input  logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  pe_start,
  output logic                  pe_valid_in,
  output logic                  pe_last,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  input  logic [ACC_WIDTH-1:0]  pe_c,
  input  logic                  pe_output_valid
`ifdef PE_DOT_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [15:0]           perf_cmds,
  output logic [15:0]           perf_timeouts
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(CLEAR_CYCLES);

  sched_state_e         state, next_state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] issue_cnt;
  logic [CW-1:0]        clear_cnt;
  logic [TW-1:0]        wait_cnt;

  logic accept, issue_last, clear_done, wait_expire;

  assign accept      = bus.cmd_valid & bus.cmd_ready;
  assign issue_last  = (issue_cnt == len_q - LEN_WIDTH'(1));
  assign clear_done  = (clear_cnt == CW'(CLEAR_CYCLES - 1));
  assign wait_expire = (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    next_state    = state;
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    a_rd_en       = 1'b0;
    b_rd_en       = 1'b0;
    pe_start      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (accept) next_state = (bus.cmd_len == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        pe_start = 1'b1;
        if (clear_done) next_state = S_ISSUE;
      end
      S_ISSUE: begin
        a_rd_en = 1'b1;
        b_rd_en = 1'b1;
        if (issue_last) next_state = S_WAIT;
      end
      S_WAIT: begin
        if (pe_output_valid || wait_expire) next_state = S_DONE;
      end
      S_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Counters, command latch and result capture; a result is written only on accept or in WAIT.
  always_ff @(posedge clk) begin
    if (clr) begin
      len_q           <= '0;
      issue_cnt       <= '0;
      clear_cnt       <= '0;
      wait_cnt        <= '0;
      bus.res_data    <= '0;
      bus.res_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            len_q           <= bus.cmd_len;
            issue_cnt       <= '0;
            clear_cnt       <= '0;
            bus.res_data    <= '0;
            bus.res_timeout <= 1'b0;
          end
        end
        S_CLEAR: clear_cnt <= clear_cnt + CW'(1);
        S_ISSUE: begin
          issue_cnt <= issue_cnt + LEN_WIDTH'(1);
          wait_cnt  <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + TW'(1);
          if (pe_output_valid) begin
            bus.res_data    <= pe_c;
            bus.res_timeout <= 1'b0;
          end else if (wait_expire) begin
            bus.res_data    <= '0;
            bus.res_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // PE controls trail the read by one cycle so they line up with the RAM data.
  always_ff @(posedge clk) begin
    if (clr) begin
      pe_valid_in <= 1'b0;
      pe_last     <= 1'b0;
    end else begin
      pe_valid_in <= a_rd_en;
      pe_last     <= a_rd_en & issue_last;
    end
  end

  assign pe_a = a_rd_data;
  assign pe_b = b_rd_data;

  pe_sched_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_a (
    .clk    (clk),
    .clr    (clr),
    .load   (accept),
    .step   (a_rd_en),
    .base   (bus.cmd_a_base),
    .stride (bus.cmd_a_stride),
    .addr   (a_rd_addr)
  );

  pe_sched_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_b (
    .clk    (clk),
    .clr    (clr),
    .load   (accept),
    .step   (b_rd_en),
    .base   (bus.cmd_b_base),
    .stride (bus.cmd_b_stride),
    .addr   (b_rd_addr)
  );

`ifdef PE_DOT_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      perf_busy_cycles <= '0;
      perf_cmds        <= '0;
      perf_timeouts    <= '0;
    end else begin
      if (state != S_IDLE && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (accept && perf_cmds != '1)                 perf_cmds        <= perf_cmds + 16'd1;
      if (state == S_WAIT && !pe_output_valid && wait_expire && perf_timeouts != '1)
        perf_timeouts <= perf_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_dot_sched.sv
// Directed bench for pe_dot_sched with behavioural operand RAMs and a 3-stage MAC PE model.
module tb_pe_dot_sched;

  localparam int DW   = 32;
  localparam int ACCW = 64;
  localparam int AW   = 4;
  localparam int LW   = 10;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic            a_rd_en, b_rd_en;
  logic [AW-1:0]   a_rd_addr, b_rd_addr;
  logic [DW-1:0]   a_rd_data = '0, b_rd_data = '0;
  logic            pe_start, pe_valid_in, pe_last;
  logic [DW-1:0]   pe_a, pe_b;
  logic [ACCW-1:0] pe_c;
  logic            pe_output_valid;
  logic            pe_stub = 1'b0;

  pe_dot_sched_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ACC_WIDTH(ACCW)) bus ();

`ifdef PE_DOT_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_cmds, perf_timeouts;
`endif

  pe_dot_sched #(
    .DATA_WIDTH(DW), .ACC_WIDTH(ACCW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(16)
  ) dut (
    .clk             (clk),
    .clr             (clr),
    .bus             (bus),
    .a_rd_en         (a_rd_en),
    .b_rd_en         (b_rd_en),
    .a_rd_addr       (a_rd_addr),
    .b_rd_addr       (b_rd_addr),
    .a_rd_data       (a_rd_data),
    .b_rd_data       (b_rd_data),
    .pe_start        (pe_start),
    .pe_valid_in     (pe_valid_in),
    .pe_last         (pe_last),
    .pe_a            (pe_a),
    .pe_b            (pe_b),
    .pe_c            (pe_c),
    .pe_output_valid (pe_output_valid)
`ifdef PE_DOT_SCHED_PERF_EN
    ,
    .perf_busy_cycles(perf_busy_cycles),
    .perf_cmds       (perf_cmds),
    .perf_timeouts   (perf_timeouts)
`endif
  );

  // Operand RAMs with one cycle of read latency.
  logic [DW-1:0] ram_a [16];
  logic [DW-1:0] ram_b [16];
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= ram_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= ram_b[b_rd_addr];
  end

  // MAC PE: input register, multiply, accumulate; start clears, output_valid pulses with last.
  logic [DW-1:0]   s1_a = '0, s1_b = '0;
  logic            s1_v = 1'b0, s1_l = 1'b0, s1_s = 1'b0;
  logic [ACCW-1:0] s2_p = '0;
  logic            s2_v = 1'b0, s2_l = 1'b0, s2_s = 1'b0;
  logic [ACCW-1:0] acc = '0, c_q = '0;
  logic            ov_q = 1'b0;
  always @(posedge clk) begin
    s1_a <= pe_a;  s1_b <= pe_b;
    s1_v <= pe_valid_in;  s1_l <= pe_last;  s1_s <= pe_start;
    s2_p <= ACCW'(s1_a) * ACCW'(s1_b);
    s2_v <= s1_v;  s2_l <= s1_l;  s2_s <= s1_s;
    if (s2_s)      acc <= '0;
    else if (s2_v) acc <= acc + s2_p;
    ov_q <= s2_v & s2_l & ~s2_s;
    if (s2_v & s2_l) c_q <= acc + s2_p;
  end
  assign pe_c            = c_q;
  assign pe_output_valid = ov_q & ~pe_stub;

  // Activity monitors.
  int            rd_cnt = 0;
  int            start_cnt = 0;
  logic [AW-1:0] a_log [$];
  always @(posedge clk) begin
    if (a_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      a_log.push_back(a_rd_addr);
    end
    if (pe_start) start_cnt <= start_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a command, waits (bounded) for cmd_ready, and returns one step after the accept edge.
  task automatic send_cmd(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                          input logic [AW-1:0] as, input logic [AW-1:0] bs,
                          input logic [LW-1:0] len);
    int n;
    bus.cmd_a_base   = ab;
    bus.cmd_b_base   = bb;
    bus.cmd_a_stride = as;
    bus.cmd_b_stride = bs;
    bus.cmd_len      = len;
    bus.cmd_valid    = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_seen", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Returns the cycle number (accept edge = 0) in which res_valid is first seen.
  task automatic wait_res(input int limit, output int cyc);
    cyc = 1;
    while (!bus.res_valid && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int rd0, st0, log0;

    bus.cmd_valid = 1'b0;
    bus.cmd_a_base = '0;  bus.cmd_b_base = '0;
    bus.cmd_a_stride = '0;  bus.cmd_b_stride = '0;
    bus.cmd_len = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
    end

    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_timeout", bus.res_timeout, 0);
    check("rst_rd_en", a_rd_en | b_rd_en, 0);
    check("rst_pe_start", pe_start, 0);
    check("rst_pe_valid_in", pe_valid_in, 0);
    check("rst_pe_last", pe_last, 0);
    clr = 1'b0;
    tick();

    // K=4 dot product: 1*5+2*6+3*7+4*8 = 70, res_valid in cycle 12
    ram_a[0] = 1; ram_a[1] = 2; ram_a[2] = 3; ram_a[3] = 4;
    ram_b[0] = 5; ram_b[1] = 6; ram_b[2] = 7; ram_b[3] = 8;
    rd0 = rd_cnt;  st0 = start_cnt;
    send_cmd(0, 0, 1, 1, 4);
    check("k4_busy_cmd_ready", bus.cmd_ready, 0);
    wait_res(40, cyc);
    check("k4_latency", cyc, 12);
    check("k4_res_data", bus.res_data, 70);
    check("k4_res_timeout", bus.res_timeout, 0);
    check("k4_rd_count", rd_cnt - rd0, 4);
    check("k4_start_count", start_cnt - st0, 3);
    tick();
    tick();
    check("k4_hold_valid", bus.res_valid, 1);
    check("k4_hold_data", bus.res_data, 70);
    take_res();
    check("k4_released", bus.res_valid, 0);
    check("k4_idle_ready", bus.cmd_ready, 1);

    // Back-to-back with res_ready high: {2,2,2}.{2,2,2}=12, then {3,3}.{3,3}=18
    ram_a[0] = 2; ram_a[1] = 2; ram_a[2] = 2;
    ram_b[0] = 2; ram_b[1] = 2; ram_b[2] = 2;
    ram_a[8] = 3; ram_a[9] = 3;
    ram_b[8] = 3; ram_b[9] = 3;
    bus.res_ready = 1'b1;
    send_cmd(0, 0, 1, 1, 3);
    wait_res(40, cyc);
    check("b2b1_latency", cyc, 11);
    check("b2b1_res_data", bus.res_data, 12);
    check("b2b1_done_not_ready", bus.cmd_ready, 0);
    send_cmd(8, 8, 1, 1, 2);
    wait_res(40, cyc);
    check("b2b2_latency", cyc, 10);
    check("b2b2_res_data", bus.res_data, 18);
    tick();
    bus.res_ready = 1'b0;
    check("b2b2_idle_ready", bus.cmd_ready, 1);

    // Zero length: immediate result, no RAM or PE activity
    rd0 = rd_cnt;  st0 = start_cnt;
    send_cmd(0, 0, 1, 1, 0);
    wait_res(10, cyc);
    check("len0_within_2", (cyc <= 2), 1);
    check("len0_res_valid", bus.res_valid, 1);
    check("len0_res_data", bus.res_data, 0);
    check("len0_res_timeout", bus.res_timeout, 0);
    tick();
    check("len0_rd_count", rd_cnt - rd0, 0);
    check("len0_start_count", start_cnt - st0, 0);
    take_res();

    // Silent PE: WAIT entered in cycle 6 for K=2, timeout result 16 cycles later
    pe_stub = 1'b1;
    send_cmd(0, 0, 1, 1, 2);
    wait_res(60, cyc);
    check("tmo_latency", cyc, 22);
    check("tmo_res_timeout", bus.res_timeout, 1);
    check("tmo_res_data", bus.res_data, 0);
    take_res();
    pe_stub = 1'b0;

    // Address wrap: base 14, stride 3 in 4-bit space -> 14, 1, 4; sum 1+2+3 = 6
    ram_a[14] = 1; ram_a[1] = 2; ram_a[4] = 3;
    ram_b[0] = 1;  ram_b[1] = 1; ram_b[2] = 1;
    log0 = a_log.size();
    send_cmd(14, 0, 3, 1, 3);
    wait_res(40, cyc);
    check("wrap_rd_count", a_log.size() - log0, 3);
    if (a_log.size() >= log0 + 3) begin
      check("wrap_addr0", a_log[log0], 14);
      check("wrap_addr1", a_log[log0 + 1], 1);
      check("wrap_addr2", a_log[log0 + 2], 4);
    end
    check("wrap_res_data", bus.res_data, 6);
    take_res();

    // Reset mid-ISSUE, then K=2 of ones must give 2 with nothing stale
    for (int i = 0; i < 4; i++) begin
      ram_a[i] = 5;
      ram_b[i] = 5;
    end
    ram_a[8] = 1; ram_a[9] = 1;
    ram_b[8] = 1; ram_b[9] = 1;
    send_cmd(0, 0, 1, 1, 4);
    tick(); tick(); tick(); tick();
    check("midrst_in_issue", a_rd_en, 1);
    clr = 1'b1;
    tick();
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_rd_en", a_rd_en, 0);
    check("midrst_pe_valid_in", pe_valid_in, 0);
    clr = 1'b0;
    send_cmd(8, 8, 1, 1, 2);
    wait_res(40, cyc);
    check("midrst_latency", cyc, 10);
    check("midrst_res_data", bus.res_data, 2);
    check("midrst_res_timeout", bus.res_timeout, 0);
    take_res();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
